// File: rtl/uart_pwm_led_ctrl_if.sv
// Pin bundle of the UART-commanded PWM LED controller.
// The slave side is the controller; the master side is the board or bench driving it.
interface uart_pwm_led_ctrl_if #(
   parameter int NUM_LEDS = 6
);
   logic                ena;
   logic                rx;
   logic                tx;
   logic [NUM_LEDS-1:0] led;
   logic                rx_valid;
   logic                frame_err;
   logic                tx_busy;

   modport master (
      output ena, rx,
      input  tx, led, rx_valid, frame_err, tx_busy
   );

   modport slave (
      input  ena, rx,
      output tx, led, rx_valid, frame_err, tx_busy
   );
endinterface

// File: rtl/uart_pwm_led_ctrl.sv
// UART (8N1) command receiver driving NUM_LEDS 4-bit PWM channels,
// with an echo / '?' response transmitter backed by a one-entry pending slot.
module uart_pwm_led_ctrl #(
   parameter int CLKS_PER_BIT = 87,
   parameter int NUM_LEDS     = 6,
   parameter int PWM_DIV      = 64
) (
   input  logic               clk,
   input  logic               rst_n,
   uart_pwm_led_ctrl_if.slave bus
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [PW-1:0] PRE_LAST  = PW'(PWM_DIV - 1);
   localparam logic [3:0]    NUM_CH    = 4'(NUM_LEDS);

   localparam logic [1:0] RX_IDLE  = 2'd0;
   localparam logic [1:0] RX_START = 2'd1;
   localparam logic [1:0] RX_DATA  = 2'd2;
   localparam logic [1:0] RX_STOP  = 2'd3;

   // RX side
   logic          rx_meta_q;
   logic          rx_sync_q;
   logic          rx_prev_q;
   logic          rx_fall;
   logic [1:0]    rx_state_q, rx_state_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]    rx_bit_q, rx_bit_d;
   logic [7:0]    rx_shift_q, rx_shift_d;
   logic          rx_done;
   logic          byte_ok;
   logic          rx_valid_q;
   logic          frame_err_q;

   // Command decode and PWM
   logic [3:0]          cmd_ch;
   logic [3:0]          cmd_duty;
   logic                cmd_hit;
   logic                cmd_bcast;
   logic [7:0]          resp_byte;
   logic [3:0]          duty_q [NUM_LEDS];
   logic [PW-1:0]       pre_q;
   logic [3:0]          pwm_cnt_q;
   logic [NUM_LEDS-1:0] led_q;

   // TX side
   logic          tx_q, tx_d;
   logic          tx_busy_q, tx_busy_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d;
   logic [3:0]    tx_bit_q, tx_bit_d;
   logic [8:0]    tx_shift_q, tx_shift_d;
   logic          pend_valid_q, pend_valid_d;
   logic [7:0]    pend_q, pend_d;
   logic          tx_load;
   logic [7:0]    tx_load_byte;
   logic          frame_end;

   // rx idles high, so the synchroniser resets to 1 to avoid a false start edge.
   // NOTE: clocked blocks use <= so every flop samples the pre-edge value of its neighbours.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_meta_q <= bus.rx;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
      end
   end

   assign rx_fall = rx_prev_q & ~rx_sync_q;

   // NOTE: every _d gets its hold value first, so no path through the case infers a latch.
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_done    = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            if (rx_fall) begin
               rx_state_d = RX_START;
               rx_cnt_d   = '0;
               rx_bit_d   = 3'd0;
            end
         end
         RX_START: begin
            if (rx_cnt_q == HALF_LAST) begin
               rx_cnt_d   = '0;
               rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         RX_DATA: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
               if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
               else                  rx_bit_d   = rx_bit_q + 3'd1;
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         RX_STOP: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d   = '0;
               rx_done    = 1'b1;
               rx_state_d = RX_IDLE;
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
      if (!bus.ena) begin
         rx_state_d = RX_IDLE;
         rx_cnt_d   = '0;
         rx_done    = 1'b0;
      end
   end

   assign byte_ok = rx_done & rx_sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state_q  <= RX_IDLE;
         rx_cnt_q    <= '0;
         rx_bit_q    <= 3'd0;
         rx_shift_q  <= 8'h00;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         rx_state_q  <= rx_state_d;
         rx_cnt_q    <= rx_cnt_d;
         rx_bit_q    <= rx_bit_d;
         rx_shift_q  <= rx_shift_d;
         rx_valid_q  <= byte_ok;
         frame_err_q <= rx_done & ~rx_sync_q;
      end
   end

   // rx_shift_q holds the received byte from the stop sample until the next frame's data.
   assign cmd_ch    = rx_shift_q[7:4];
   assign cmd_duty  = rx_shift_q[3:0];
   assign cmd_bcast = (cmd_ch == 4'hF);
   assign cmd_hit   = (cmd_ch < NUM_CH);
   assign resp_byte = (cmd_hit || cmd_bcast) ? rx_shift_q : 8'h3F;

   // NOTE: the duty array is a handful of flops that must come up dark, so it is reset
   // like ordinary registers rather than treated as an unreset RAM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_LEDS; k++) duty_q[k] <= 4'h0;
      end else if (byte_ok) begin
         for (int k = 0; k < NUM_LEDS; k++) begin
            if (cmd_bcast || (cmd_hit && (cmd_ch == 4'(k)))) duty_q[k] <= cmd_duty;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q     <= '0;
         pwm_cnt_q <= 4'h0;
         led_q     <= '0;
      end else begin
         if (pre_q == PRE_LAST) begin
            pre_q     <= '0;
            pwm_cnt_q <= pwm_cnt_q + 4'd1;
         end else begin
            pre_q <= pre_q + 1'b1;
         end
         for (int k = 0; k < NUM_LEDS; k++) begin
            led_q[k] <= bus.ena & ((duty_q[k] == 4'hF) | (pwm_cnt_q < duty_q[k]));
         end
      end
   end

   // A frame ends on the last cycle of its stop bit; the next one may start on the very next cycle.
   always_comb begin
      tx_d         = tx_q;
      tx_busy_d    = tx_busy_q;
      tx_cnt_d     = tx_cnt_q;
      tx_bit_d     = tx_bit_q;
      tx_shift_d   = tx_shift_q;
      pend_valid_d = pend_valid_q;
      pend_d       = pend_q;
      tx_load      = 1'b0;
      tx_load_byte = pend_q;
      frame_end    = tx_busy_q && (tx_cnt_q == BIT_LAST) && (tx_bit_q == 4'd0);

      if (!tx_busy_q || frame_end) begin
         if (pend_valid_q) begin
            tx_load      = 1'b1;
            tx_load_byte = pend_q;
            pend_valid_d = 1'b0;
         end else if (rx_valid_q) begin
            tx_load      = 1'b1;
            tx_load_byte = resp_byte;
         end else if (frame_end) begin
            tx_busy_d = 1'b0;
            tx_d      = 1'b1;
            tx_cnt_d  = '0;
         end
      end else if (tx_cnt_q == BIT_LAST) begin
         tx_cnt_d   = '0;
         tx_d       = tx_shift_q[0];
         tx_shift_d = {1'b1, tx_shift_q[8:1]};
         tx_bit_d   = tx_bit_q - 4'd1;
      end else begin
         tx_cnt_d = tx_cnt_q + 1'b1;
      end

      if (tx_load) begin
         tx_d       = 1'b0;
         tx_busy_d  = 1'b1;
         tx_cnt_d   = '0;
         tx_bit_d   = 4'd9;
         tx_shift_d = {1'b1, tx_load_byte};
      end

      // A response not sent directly takes the pending slot if free, otherwise it is dropped.
      if (rx_valid_q && !(tx_load && !pend_valid_q) && !pend_valid_d) begin
         pend_valid_d = 1'b1;
         pend_d       = resp_byte;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_q         <= 1'b1;
         tx_busy_q    <= 1'b0;
         tx_cnt_q     <= '0;
         tx_bit_q     <= 4'd0;
         tx_shift_q   <= 9'h1FF;
         pend_valid_q <= 1'b0;
         pend_q       <= 8'h00;
      end else begin
         tx_q         <= tx_d;
         tx_busy_q    <= tx_busy_d;
         tx_cnt_q     <= tx_cnt_d;
         tx_bit_q     <= tx_bit_d;
         tx_shift_q   <= tx_shift_d;
         pend_valid_q <= pend_valid_d;
         pend_q       <= pend_d;
      end
   end

   assign bus.tx        = tx_q;
   assign bus.tx_busy   = tx_busy_q;
   assign bus.led       = led_q;
   assign bus.rx_valid  = rx_valid_q;
   assign bus.frame_err = frame_err_q;

endmodule
